// File: rtl/seno_pkg.sv
// Shared widths, quadrant encoding and the quarter-wave sine table generator
// for the seno DDS core.
package seno_pkg;

  localparam int PHASE_W    = 32;
  localparam int DATA_W     = 16;
  localparam int LUT_ADDR_W = 8;
  localparam int LUT_DEPTH  = 1 << LUT_ADDR_W;
  localparam int LUT_FRAC   = 60;

  localparam logic [DATA_W-1:0] AMP_ONE = 16'h8000;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_e;

  // round(32767 * sin(pi/2 * (idx + 0.5) / 256)) in Q60 integer arithmetic,
  // so the table can be elaborated without real-valued math.
  function automatic logic [DATA_W-1:0] lut_value(input int idx);
    logic [127:0] pio2;
    logic [127:0] one;
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] t;
    logic [127:0] s;
    logic [127:0] y;
    pio2 = 128'h1921FB54442D1846;
    one  = 128'(1) << LUT_FRAC;
    x    = (pio2 * 128'(2 * idx + 1)) >> (LUT_ADDR_W + 1);
    x2   = (x * x) >> LUT_FRAC;
    t    = one;
    for (int k = 7; k >= 1; k--) begin
      t = one - (((x2 * t) >> LUT_FRAC) / 128'(2 * k * (2 * k + 1)));
    end
    s = (x * t) >> LUT_FRAC;
    y = (s * 128'((1 << (DATA_W - 1)) - 1) + (one >> 1)) >> LUT_FRAC;
    return y[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/seno_dds_core_if.sv
// Sample stream toward the DAC / stream sink: valid/ready handshake with
// signed sample data.
interface seno_dds_core_if;
  import seno_pkg::*;

  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;

  modport master (output m_tvalid, output m_tdata, input m_tready);
  modport slave  (input m_tvalid, input m_tdata, output m_tready);

endinterface

// File: rtl/seno_lut_cuarto.sv
// Quarter-wave sine ROM with a registered read that holds while en_i is low.
module seno_lut_cuarto
  import seno_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [LUT_ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0]     data_o
);

  logic [DATA_W-1:0] rom [LUT_DEPTH];
  logic [DATA_W-1:0] data_q;

  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
    localparam logic [DATA_W-1:0] VAL = lut_value(g);
    assign rom[g] = VAL;
  end

  // NOTE: the table is constant logic, so only the read register needs a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= rom[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/seno_dds_core.sv
// Sine sample generator: phase accumulator, quadrant fold, quarter-wave ROM,
// Q1.15 amplitude scaling and saturating offset behind a valid/ready stream.
module seno_dds_core
  import seno_pkg::*;
(
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               cfg_enable,
  input  logic               cfg_phase_clr,
  input  logic [PHASE_W-1:0] cfg_phase_inc,
  input  logic [DATA_W-1:0]  cfg_amplitude,
  input  logic [DATA_W-1:0]  cfg_offset,
  seno_dds_core_if.master    m_axis,
  output logic               busy
);

  localparam int FOLD_W = LUT_ADDR_W + 2;
  localparam int PROD_W = 2 * DATA_W + 2;
  localparam logic signed [DATA_W:0] SAT_MAX = (DATA_W + 1)'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [DATA_W:0] SAT_MIN = (DATA_W + 1)'(-(1 << (DATA_W - 1)));

  logic                     adv;
  logic [PHASE_W-1:0]       acc_q, acc_d;
  logic                     p1_valid_q;
  logic [FOLD_W-1:0]        p1_phase_q;
  quadrant_e                quad;
  logic [LUT_ADDR_W-1:0]    lut_idx, rom_addr;
  logic [DATA_W-1:0]        rom_data;
  logic                     p2_valid_q, p2_sign_q;
  logic [DATA_W-1:0]        amp_sat;
  logic signed [PROD_W-1:0] lut_w, amp_w;
  logic signed [DATA_W:0]   prod_d, p3_prod_q;
  logic                     p3_valid_q;
  logic signed [DATA_W:0]   sum;
  logic [DATA_W-1:0]        tdata_d, tdata_q;
  logic                     tvalid_q;

  // Whole pipeline freezes only while the output holds an unaccepted sample.
  assign adv = !(tvalid_q && !m_axis.m_tready);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    acc_d = acc_q;
    if (cfg_phase_clr) begin
      acc_d = '0;
    end else if (adv && cfg_enable) begin
      acc_d = acc_q + cfg_phase_inc;
    end
  end

  // Odd quadrants read the table backwards; the lower half of the wave is negated.
  assign quad     = quadrant_e'(p1_phase_q[FOLD_W-1 -: 2]);
  assign lut_idx  = p1_phase_q[LUT_ADDR_W-1:0];
  assign rom_addr = (quad == Q1 || quad == Q3) ? ~lut_idx : lut_idx;

  seno_lut_cuarto u_lut (
    .clk    (ACLK),
    .rst    (ARESET),
    .en_i   (adv),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_comb begin
    amp_sat = (cfg_amplitude > AMP_ONE) ? AMP_ONE : cfg_amplitude;
    lut_w   = PROD_W'(rom_data);
    if (p2_sign_q) begin
      lut_w = -lut_w;
    end
    amp_w  = PROD_W'(amp_sat);
    prod_d = (DATA_W + 1)'((lut_w * amp_w) >>> (DATA_W - 1));
  end

  always_comb begin
    sum     = p3_prod_q + (DATA_W + 1)'(signed'(cfg_offset));
    tdata_d = sum[DATA_W-1:0];
    if (sum > SAT_MAX) begin
      tdata_d = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (sum < SAT_MIN) begin
      tdata_d = {1'b1, {(DATA_W - 1){1'b0}}};
    end
  end

  // NOTE: non-blocking updates make each stage take its neighbour's pre-edge value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      acc_q      <= '0;
      p1_valid_q <= 1'b0;
      p1_phase_q <= '0;
      p2_valid_q <= 1'b0;
      p2_sign_q  <= 1'b0;
      p3_valid_q <= 1'b0;
      p3_prod_q  <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
    end else begin
      acc_q <= acc_d;
      if (adv) begin
        p1_valid_q <= cfg_enable;
        p1_phase_q <= acc_q[PHASE_W-1 -: FOLD_W];
        p2_valid_q <= p1_valid_q;
        p2_sign_q  <= (quad == Q2 || quad == Q3);
        p3_valid_q <= p2_valid_q;
        p3_prod_q  <= prod_d;
        tvalid_q   <= p3_valid_q;
        tdata_q    <= tdata_d;
      end
    end
  end

  assign m_axis.m_tvalid = tvalid_q;
  assign m_axis.m_tdata  = tdata_q;
  assign busy            = p1_valid_q | p2_valid_q | p3_valid_q | tvalid_q;

endmodule

// File: tb/tb_seno_dds_core.sv
// Self-checking bench for seno_dds_core: directed spec scenarios plus random
// configurations and backpressure, compared against a real-valued sine model.
module tb_seno_dds_core;
  import seno_pkg::*;

  localparam real PI = 3.14159265358979323846;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cfg_enable;
  logic        cfg_phase_clr;
  logic [31:0] cfg_phase_inc;
  logic [15:0] cfg_amplitude;
  logic [15:0] cfg_offset;
  logic        busy;

  seno_dds_core_if axis ();

  seno_dds_core dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cfg_enable    (cfg_enable),
    .cfg_phase_clr (cfg_phase_clr),
    .cfg_phase_inc (cfg_phase_inc),
    .cfg_amplitude (cfg_amplitude),
    .cfg_offset    (cfg_offset),
    .m_axis        (axis),
    .busy          (busy)
  );

  always #5 ACLK = ~ACLK;

  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_q[$];
  int          rx_q[$];
  logic [31:0] model_acc = '0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  int          base = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Sample n of a 1024-point period: round(32767*sin(2*pi*(n+0.5)/1024)),
  // scaled by min(amp,1.0) with floor, then offset and clamped to 16 bits.
  function automatic int model_sample(input logic [31:0] ph, input logic [15:0] amp,
                                      input logic [15:0] off);
    int     n;
    real    r;
    int     s;
    int     a;
    longint p;
    int     sum;
    n   = int'(ph[31:22]);
    r   = 32767.0 * $sin(2.0 * PI * (real'(n) + 0.5) / 1024.0);
    s   = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    a   = (amp > 16'h8000) ? 32768 : int'(amp);
    p   = longint'(s) * longint'(a);
    sum = int'(p >>> 15) + int'($signed(off));
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
    return sum;
  endfunction

  // Observe at the falling edge what the next rising edge will do.
  always @(negedge ACLK) begin
    if (ARESET) begin
      exp_q.delete();
      model_acc  = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", axis.m_tvalid, 1);
        check("hold_data", axis.m_tdata, prev_data);
      end
      if (axis.m_tvalid && axis.m_tready) begin
        rx_q.push_back(int'($signed(axis.m_tdata)));
        if (exp_q.size() == 0) check("unexpected_sample", exp_q.size(), 1);
        else check("sample", $signed(axis.m_tdata), exp_q.pop_front());
      end
      if (cfg_enable && !(axis.m_tvalid && !axis.m_tready)) begin
        exp_q.push_back(model_sample(model_acc, cfg_amplitude, cfg_offset));
        model_acc = model_acc + cfg_phase_inc;
      end
      if (cfg_phase_clr) model_acc = '0;
      prev_stall = axis.m_tvalid && !axis.m_tready;
      prev_data  = axis.m_tdata;
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic int rx(input int k);
    if (base + k < rx_q.size()) return rx_q[base + k];
    return -99999;
  endfunction

  task automatic wait_rx(input int target, input bit rnd);
    int cyc = 0;
    while (rx_q.size() < target && cyc < 5000) begin
      tick();
      cyc++;
      if (rnd) axis.m_tready = ($urandom_range(3) != 0);
    end
    axis.m_tready = 1'b1;
    check("wait_rx_done", rx_q.size() >= target, 1);
  endtask

  task automatic clear_acc();
    cfg_phase_clr = 1'b1;
    tick();
    cfg_phase_clr = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    cfg_enable = 1'b0;
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end
    check("drain_busy", busy, 0);
    check("drain_pending", exp_q.size(), 0);
    clear_acc();
  endtask

  task automatic start(input logic [31:0] inc, input logic [15:0] amp, input logic [15:0] off);
    cfg_phase_inc = inc;
    cfg_amplitude = amp;
    cfg_offset    = off;
    base          = rx_q.size();
    cfg_enable    = 1'b1;
  endtask

  localparam logic [31:0] INC256 = 32'h0100_0000;

  initial begin
    ARESET        = 1'b1;
    cfg_enable    = 1'b0;
    cfg_phase_clr = 1'b0;
    cfg_phase_inc = '0;
    cfg_amplitude = '0;
    cfg_offset    = '0;
    axis.m_tready = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", axis.m_tvalid, 0);
    check("rst_tdata", axis.m_tdata, 0);
    check("rst_busy", busy, 0);
    ARESET = 1'b0;
    tick();

    // DC output, first-sample latency and busy fall-off
    start(32'h0, 16'h8000, 16'h0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("latency_e%0d", e), axis.m_tvalid, (e == 4));
    end
    wait_rx(base + 8, 1'b0);
    check("dc_sample3", rx(3), 101);
    cfg_enable = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("busy_fall_e%0d", e), busy, (e < 4));
    end
    drain();

    start(INC256, 16'h8000, 16'h0);
    wait_rx(base + 257, 1'b0);
    drain();
    check("quad_s0", rx(0), 101);
    check("quad_s64", rx(64), 32767);
    check("quad_s128", rx(128), -101);
    check("quad_s192", rx(192), -32767);
    check("quad_s256", rx(256), 101);

    start(INC256, 16'h4000, 16'h0);
    wait_rx(base + 65, 1'b0);
    drain();
    check("amp_half_s64", rx(64), 16383);

    start(INC256, 16'hFFFF, 16'h0);
    wait_rx(base + 65, 1'b0);
    drain();
    check("amp_clamp_s64", rx(64), 32767);

    start(INC256, 16'h8000, 16'h7000);
    wait_rx(base + 65, 1'b0);
    drain();
    check("sat_pos_s64", rx(64), 32767);

    start(INC256, 16'h8000, 16'h9000);
    wait_rx(base + 193, 1'b0);
    drain();
    check("sat_neg_s192", rx(192), -32768);

    // Hold sample 5 under backpressure for 10 cycles
    start(INC256, 16'h8000, 16'h0);
    wait_rx(base + 5, 1'b0);
    axis.m_tready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_valid", axis.m_tvalid, 1);
      check("bp_data", $signed(axis.m_tdata), model_sample(INC256 * 5, 16'h8000, 16'h0));
    end
    axis.m_tready = 1'b1;
    wait_rx(base + 20, 1'b0);
    drain();
    check("bp_s5", rx(5), model_sample(INC256 * 5, 16'h8000, 16'h0));
    check("bp_s6", rx(6), model_sample(INC256 * 6, 16'h8000, 16'h0));

    // Clear while streaming: sample 14 issues with the old phase, 15 restarts at 0
    start(INC256, 16'h8000, 16'h0);
    wait_rx(base + 10, 1'b0);
    cfg_phase_clr = 1'b1;
    tick();
    cfg_phase_clr = 1'b0;
    wait_rx(base + 30, 1'b0);
    drain();
    check("clr_s14", rx(14), model_sample(INC256 * 14, 16'h8000, 16'h0));
    check("clr_s15", rx(15), 101);
    check("clr_s16", rx(16), model_sample(INC256, 16'h8000, 16'h0));

    for (int r = 0; r < 4; r++) begin
      start($urandom, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      wait_rx(base + 80, 1'b1);
      drain();
    end

    // Reset in the middle of a stream
    start(INC256, 16'h8000, 16'h0);
    wait_rx(base + 10, 1'b0);
    check("pre_reset_valid", axis.m_tvalid, 1);
    #2;
    ARESET = 1'b1;
    #1;
    check("mid_rst_tvalid", axis.m_tvalid, 0);
    check("mid_rst_tdata", axis.m_tdata, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    tick();
    ARESET = 1'b0;
    base   = rx_q.size();
    wait_rx(base + 5, 1'b0);
    drain();
    check("post_rst_s0", rx(0), 101);
    check("post_rst_s1", rx(1), model_sample(INC256, 16'h8000, 16'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
